multi_cycle_control_unit: RTL and testbench
===========================================

Name: multi_cycle_control_unit

Overview:
- Control FSM for the multi-cycle RV32I datapath; successor to the single-cycle combinational opcode decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB over one shared memory and ALU.
- Memory latency is parametrised, and the block stretches IF and MEM by a wait counter.
- Drives every datapath mux and enable, and owns the ecall/halt decision.

Parameters:
- MEM_LATENCY, 1, cycles a memory access is held (mem_read/mem_write asserted); must be >= 1.
- HALT_ON_ECALL, 1, 1: ecall with halt_cond enters HALTED; 0: ecall is always a NOP.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0]; stable from ID onward
- bcond  in  1  ALU branch-compare result, valid in EX
- halt_cond  in  1  x17 == 10, from register file read in ID
- pc_write  out  1  PC register load enable
- pc_source  out  1  PC next: 0 = ALU result, 1 = ALUOut
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR/old_pc/MDR capture enable
- mem_to_reg  out  1  rd data: 1 = MDR, 0 = ALUOut (when pc_to_reg = 0)
- pc_to_reg  out  1  rd data = current PC (link value)
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = old_pc, 1 = rs1 latch A
- alu_src_b  out  2  00 = B latch, 01 = imm, 10 = const 4
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded
- is_ecall  out  1  high in ID when opcode == ECALL
- is_halted  out  1  high in HALTED

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset: state = IF, wait counter = 0. While reset is high, all outputs are forced to 0.
- Outputs are combinational from state, opcode, counter and bcond. Unlisted outputs are 0 in every state.
- IF:
  - mem_read = 1, i_or_d = 0.
  - Counter counts 0 .. MEM_LATENCY-1.
  - On the final count: ir_write = 1, counter clears, next state = ID.
- ID:
  - a = 0, b = 10, op = 00, pc_write = 1, pc_source = 0. PC <= PC + 4; old_pc keeps the instruction address.
  - opcode ECALL: is_ecall = 1. If halt_cond && HALT_ON_ECALL, next = HALTED; otherwise next = IF.
  - Any undefined opcode: next = IF (NOP).
  - All other opcodes: next = EX.
- EX:
  - ARITHMETIC: a = 1, b = 00, op = 10. Next = WB.
  - ARITHMETIC_IMM: a = 1, b = 01, op = 10. Next = WB.
  - LOAD / STORE: a = 1, b = 01, op = 00. Next = MEM.
  - BRANCH: a = 1, b = 00, op = 01. bcond = 1: next = BR_TAKEN; bcond = 0: next = IF.
  - JAL: a = 0, b = 01, op = 00, pc_write = 1, pc_source = 0, reg_write = 1, pc_to_reg = 1. Next = IF. The link value is the already-incremented PC; the jump target is old_pc + imm.
  - JALR: same as JAL but a = 1.
- BR_TAKEN: a = 0, b = 01, op = 00, pc_write = 1, pc_source = 0 (PC = old_pc + imm). Next = IF.
- MEM:
  - i_or_d = 1; mem_read = 1 for LOAD, mem_write = 1 for STORE. Held for MEM_LATENCY cycles by the counter.
  - LOAD: ir_write stays 0; MDR capture is driven by the datapath every cycle. Next = WB.
  - STORE: next = IF.
- WB: reg_write = 1; mem_to_reg = 1 for LOAD, 0 otherwise. Next = IF.
- HALTED: is_halted = 1, all other outputs 0. Left only by reset.
- Counter:
  - Width max(1, clog2(MEM_LATENCY)).
  - Clears on entering IF or MEM and on reset.
  - Never wraps: the state exits on MEM_LATENCY-1.
- Reset mid-access (IF or MEM, any count): next cycle is IF with counter = 0. No write strobe is issued in the reset cycle.
- Per-instruction cycle counts, with L = MEM_LATENCY:
  - R/I-type: L + 3.
  - LOAD: 2L + 3.
  - STORE: 2L + 2.
  - Branch not taken: L + 2; branch taken: L + 3.
  - JAL/JALR: L + 2.
  - Non-halting ecall: L + 1.

Decomposition:
- Existing shared opcodes.v: keep the opcode defines; add the ARITHMETIC_IMM define there if missing.
- New shared mc_ctrl_defs.v holds:
  - state encodings: IF, ID, EX, MEM, WB, BR_TAKEN, HALTED (3 bits);
  - ALU_OP_* codes;
  - ALU_SRC_B_* codes.
- One sub-module: mem_wait_timer.
  - Parameter MEM_LATENCY.
  - Inputs clk, reset, clear, enable.
  - Output last (count == MEM_LATENCY-1).

Test Plan:
1. MEM_LATENCY = 1, ADD (0110011) -> IF, ID, EX, WB in 4 cycles; reg_write = 1 only in WB; pc_write = 1 only in ID.
2. MEM_LATENCY = 3, LW (0000011) -> mem_read high 3 cycles in IF then 3 in MEM; i_or_d = 1 in MEM; mem_to_reg = 1 in WB; 9 cycles total.
3. BEQ (1100011) with bcond = 1 -> BR_TAKEN with pc_write = 1, a = 0, b = 01. With bcond = 0 -> IF directly after EX.
4. JAL (1101111) -> in EX, reg_write = pc_to_reg = pc_write = 1 in the same cycle; next state IF.
5. ECALL (1110011) with halt_cond = 1 -> is_ecall in ID, then is_halted stays 1 with all outputs 0. Reset -> state IF.
6. SW with MEM_LATENCY = 4, reset asserted on the 2nd MEM cycle -> mem_write = 0 during reset; next cycle IF with counter 0.

Source files
------------

// File: rtl/multi_cycle_control_unit_pkg.sv
// multi_cycle_control_unit_pkg: opcodes, state encoding and control-word layout for the multi-cycle RV32I controller
package multi_cycle_control_unit_pkg;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_BR_TAKEN, S_HALTED} state_e;
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;
  localparam logic [1:0] ALU_OP_ADD        = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH     = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT      = 2'b10;
  localparam logic [1:0] ALU_SRC_B_REG     = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       is_halted;
  } ctrl_t;
  // Opcodes that continue past ID into EX; ECALL is decided in ID
  function automatic logic is_exec_op(input logic [6:0] op);
    return op inside {OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction
endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_timer.sv
// mem_wait_timer: counts memory-access cycles and flags the final one
module mem_wait_timer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  assign last = cnt_q == CW'(MEM_LATENCY - 1);
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: IF/ID/EX/MEM/WB sequencer driving the shared-memory RV32I datapath
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int MEM_LATENCY   = 1,
  parameter int HALT_ON_ECALL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_cond,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_ecall,
  output logic       is_halted
);
  state_e state_q, state_d;
  ctrl_t  c;
  logic   busy, last;
  assign busy = state_q == S_IF || state_q == S_MEM;
  // Clearing on the last count leaves the counter at 0 on entry to the next access
  mem_wait_timer #(.MEM_LATENCY(MEM_LATENCY)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (busy && last),
    .enable(busy),
    .last  (last)
  );
  always_ff @(posedge clk) begin
    state_q <= reset ? S_IF : state_d;
  end
  always_comb begin
    c = '0;
    state_d = state_q;
    case (state_q)
      S_IF: begin
        c.mem_read = 1'b1;
        c.ir_write = last;
        state_d = last ? S_ID : S_IF;
      end
      S_ID: begin
        c.pc_write = 1'b1;
        c.alu_src_b = ALU_SRC_B_FOUR;
        c.is_ecall = opcode == OP_ECALL;
        state_d = (opcode == OP_ECALL) ? ((halt_cond && HALT_ON_ECALL != 0) ? S_HALTED : S_IF)
                : is_exec_op(opcode) ? S_EX : S_IF;
      end
      S_EX: begin
        c.alu_src_a = 1'b1;
        case (opcode)
          OP_ARITHMETIC: begin
            c.alu_op = ALU_OP_FUNCT;
            state_d = S_WB;
          end
          OP_ARITHMETIC_IMM: begin
            c.alu_src_b = ALU_SRC_B_IMM;
            c.alu_op = ALU_OP_FUNCT;
            state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            c.alu_src_b = ALU_SRC_B_IMM;
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            c.alu_op = ALU_OP_BRANCH;
            state_d = bcond ? S_BR_TAKEN : S_IF;
          end
          OP_JAL, OP_JALR: begin
            c.alu_src_a = opcode == OP_JALR;
            c.alu_src_b = ALU_SRC_B_IMM;
            c.pc_write = 1'b1;
            c.reg_write = 1'b1;
            c.pc_to_reg = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_BR_TAKEN: begin
        c.pc_write = 1'b1;
        c.alu_src_b = ALU_SRC_B_IMM;
        state_d = S_IF;
      end
      S_MEM: begin
        c.i_or_d = 1'b1;
        c.mem_read = opcode == OP_LOAD;
        c.mem_write = opcode == OP_STORE;
        state_d = !last ? S_MEM : (opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB: begin
        c.reg_write = 1'b1;
        c.mem_to_reg = opcode == OP_LOAD;
        state_d = S_IF;
      end
      S_HALTED: c.is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end
  assign {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, pc_to_reg,
          reg_write, alu_src_a, alu_src_b, alu_op, is_ecall, is_halted} = reset ? '0 : c;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: trace-model checking of the controller at several memory latencies
module tb_multi_cycle_control_unit;
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       is_ecall;
    logic       is_halted;
  } vec_t;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, EC = 7'b1110011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam int LS [4] = '{1, 3, 4, 1};
  localparam int HS [4] = '{1, 1, 1, 0};
  logic       clk = 1'b0;
  logic [3:0] rst = '1;
  logic [6:0] opcode = '0;
  logic       bcond = 1'b0;
  logic       halt_cond = 1'b0;
  vec_t       o [4];
  vec_t       expq [$];
  vec_t       tr [$];
  int         checks = 0;
  int         errors = 0;
  int         lane = 0;
  bit         m_halted = 0;
  string      tag = "idle";
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : ln
    logic pw, ps, iod, mr, mw, irw, m2r, p2r, rw, sa, ec, hl;
    logic [1:0] sb, aop;
    multi_cycle_control_unit #(.MEM_LATENCY(LS[g]), .HALT_ON_ECALL(HS[g])) dut (
      .clk(clk), .reset(rst[g]), .opcode(opcode), .bcond(bcond), .halt_cond(halt_cond),
      .pc_write(pw), .pc_source(ps), .i_or_d(iod), .mem_read(mr), .mem_write(mw),
      .ir_write(irw), .mem_to_reg(m2r), .pc_to_reg(p2r), .reg_write(rw), .alu_src_a(sa),
      .alu_src_b(sb), .alu_op(aop), .is_ecall(ec), .is_halted(hl)
    );
    assign o[g] = {pw, ps, iod, mr, mw, irw, m2r, p2r, rw, sa, sb, aop, ec, hl};
  end
  // Per-instruction trace: one expected control word per cycle, derived from the phase list
  function automatic void build(input logic [6:0] op, input bit bc, input int l);
    vec_t v;
    tr.delete();
    for (int i = 0; i < l; i++) begin
      v = '0; v.mem_read = 1; v.ir_write = (i == l - 1); tr.push_back(v);
    end
    v = '0; v.pc_write = 1; v.b = 2'b10; v.is_ecall = (op == EC); tr.push_back(v);
    if (!(op inside {R, I, LD, ST, BR, JAL, JALR})) return;
    v = '0; v.a = 1;
    if (op == R || op == I) begin
      v.b = (op == I) ? 2'b01 : 2'b00; v.op = 2'b10; tr.push_back(v);
      v = '0; v.reg_write = 1; tr.push_back(v);
    end else if (op == LD || op == ST) begin
      v.b = 2'b01; tr.push_back(v);
      for (int i = 0; i < l; i++) begin
        v = '0; v.i_or_d = 1; v.mem_read = (op == LD); v.mem_write = (op == ST); tr.push_back(v);
      end
      if (op == LD) begin
        v = '0; v.reg_write = 1; v.mem_to_reg = 1; tr.push_back(v);
      end
    end else if (op == BR) begin
      v.op = 2'b01; tr.push_back(v);
      if (bc) begin
        v = '0; v.pc_write = 1; v.b = 2'b01; tr.push_back(v);
      end
    end else begin
      v.a = (op == JALR); v.b = 2'b01; v.pc_write = 1; v.reg_write = 1; v.pc_to_reg = 1;
      tr.push_back(v);
    end
  endfunction
  task automatic pin(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL model %s: got %0h want %0h", n, got, want);
    end
  endtask
  task automatic do_reset(input int ln);
    vec_t z;
    z = '0;
    lane = ln; rst = '1; tag = "reset"; m_halted = 0;
    expq.push_back(z);
    @(posedge clk); #1;
    rst[ln] = 1'b0;
  endtask
  task automatic do_instr(input string name, input logic [6:0] op, input bit bc, input bit hc,
                          input int cut = 0);
    vec_t h;
    tag = name; opcode = op; bcond = bc; halt_cond = hc;
    if (m_halted) begin
      h = '0; h.is_halted = 1;
      tr.delete();
      repeat (4) tr.push_back(h);
    end else begin
      build(op, bc, LS[lane]);
      if (op == EC && hc && HS[lane] != 0) m_halted = 1;
    end
    if (cut > 0) while (tr.size() > cut) void'(tr.pop_back());
    foreach (tr[k]) expq.push_back(tr[k]);
    repeat (tr.size()) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    vec_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (o[lane] !== e) begin
        errors++;
        $display("FAIL lane%0d %s @%0t: got %h want %h", lane, tag, $time, o[lane], e);
      end
    end
  end
  initial begin
    build(R, 0, 1);    pin("add_len_L1", tr.size(), 4);
    pin("add_id", int'(tr[1]), 'h8020); pin("add_wb", int'(tr[3]), 'h0080);
    build(LD, 0, 3);   pin("lw_len_L3", tr.size(), 9); pin("lw_wb", int'(tr[8]), 'h0280);
    build(ST, 0, 4);   pin("sw_len_L4", tr.size(), 10);
    build(JAL, 0, 3);  pin("jal_len_L3", tr.size(), 5); pin("jal_ex", int'(tr[4]), 'h8190);
    build(BR, 1, 3);   pin("beq_t_len", tr.size(), 6); pin("beq_t_br", int'(tr[5]), 'h8010);
    build(BR, 0, 2);   pin("beq_nt_len", tr.size(), 4);
    build(EC, 0, 2);   pin("ecall_len", tr.size(), 3); pin("ecall_id", int'(tr[2]), 'h8022);
    repeat (2) @(posedge clk);
    #1;
    do_reset(0);
    do_instr("add", R, 0, 0);
    do_instr("addi", I, 0, 0);
    do_instr("undef", LUI, 0, 0);
    do_instr("jalr", JALR, 0, 0);
    do_instr("beq_nt", BR, 0, 0);
    do_instr("ecall_nop", EC, 0, 0);
    do_instr("ecall_halt", EC, 0, 1);
    do_instr("halted", R, 0, 0);
    do_reset(0);
    do_instr("add_after_halt", R, 0, 0);
    do_reset(1);
    do_instr("lw", LD, 0, 0);
    do_instr("sw", ST, 0, 0);
    do_instr("beq_t", BR, 1, 0);
    do_instr("beq_nt", BR, 0, 0);
    do_instr("jal", JAL, 0, 0);
    do_instr("add", R, 1, 1);
    do_instr("ecall_halt", EC, 0, 1);
    do_instr("halted", EC, 0, 1);
    do_reset(1);
    do_instr("lw_after_halt", LD, 0, 0);
    do_reset(2);
    do_instr("sw_cut", ST, 0, 0, 7);
    do_reset(2);
    do_instr("add_after_cut", R, 0, 0);
    do_instr("lw", LD, 0, 0);
    do_instr("sw", ST, 0, 0);
    do_reset(3);
    do_instr("ecall_no_halt", EC, 0, 1);
    do_instr("add", R, 0, 0);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
